// File: rtl/alarm_pixel_compositor_pkg.sv
// Shared definitions for the alarm-clock VGA pixel compositor.
//   - alarm_state_e : alarm display FSM state, 2-bit encoding visible on the
//                     alarm_state output (0 OFF, 1 ARMED, 2 RINGING, 3 SNOOZED)
//   - color_t       : 12-bit RGB 4:4:4 pixel colour
//   - DEF_COLOR_*   : default palette used as parameter defaults
//   - caption_visible() : whether the "ALARM" caption is drawn for a given
//                         displayed state and blink phase
package alarm_pixel_compositor_pkg;

    typedef enum logic [1:0] {
        ALARM_OFF     = 2'd0,
        ALARM_ARMED   = 2'd1,
        ALARM_RINGING = 2'd2,
        ALARM_SNOOZED = 2'd3
    } alarm_state_e;

    typedef logic [11:0] color_t;

    localparam color_t DEF_COLOR_BG           = 12'h000;
    localparam color_t DEF_COLOR_TIME         = 12'hFFF;
    localparam color_t DEF_COLOR_ALARM_DIGITS = 12'h0F0;
    localparam color_t DEF_COLOR_ALARM_TEXT   = 12'hF00;
    localparam color_t DEF_COLOR_DIM          = 12'h444;
    localparam color_t DEF_COLOR_RING_BG      = 12'h400;

    // The caption is always drawn while disabled (dimmed) or armed; while
    // ringing or snoozed it blinks with the latched phase.
    function automatic logic caption_visible(alarm_state_e st, logic phase);
        logic vis;
        vis = 1'b1;
        if ((st == ALARM_RINGING) || (st == ALARM_SNOOZED)) begin
            vis = phase;
        end
        return vis;
    endfunction

endpackage

// File: rtl/alarm_pixel_compositor_if.sv
// Pixel/alarm bundle between the renderers and the compositor.
//   Inputs to the compositor : video_on, hsync_in, vsync_in, frame_tick,
//                              time_on, alarm_digits_on, alarm_text_on,
//                              alarm_en, alarm_ringing, snooze
//   Outputs of the compositor: rgb (12-bit), hsync_out, vsync_out,
//                              alarm_state (2-bit)
// master: the upstream driver side; slave: the compositor side.
interface alarm_pixel_compositor_if;
    import alarm_pixel_compositor_pkg::*;

    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic       frame_tick;
    logic       time_on;
    logic       alarm_digits_on;
    logic       alarm_text_on;
    logic       alarm_en;
    logic       alarm_ringing;
    logic       snooze;

    color_t     rgb;
    logic       hsync_out;
    logic       vsync_out;
    logic [1:0] alarm_state;

    modport master (
        output video_on, hsync_in, vsync_in, frame_tick,
               time_on, alarm_digits_on, alarm_text_on,
               alarm_en, alarm_ringing, snooze,
        input  rgb, hsync_out, vsync_out, alarm_state
    );

    modport slave (
        input  video_on, hsync_in, vsync_in, frame_tick,
               time_on, alarm_digits_on, alarm_text_on,
               alarm_en, alarm_ringing, snooze,
        output rgb, hsync_out, vsync_out, alarm_state
    );

endinterface

// File: rtl/alarm_pixel_compositor_blink_ctrl.sv
// alarm_blink_ctrl: alarm display FSM plus frame-counted blink/snooze timing.
//   clk, reset_n      : clock, asynchronous active-low reset
//   frame_tick        : one-cycle pulse per frame (start of vblank)
//   alarm_en          : alarm enabled (level)
//   alarm_ringing     : alarm time matched (level)
//   snooze            : one-cycle snooze request, honoured only in RINGING
//   alarm_state       : live FSM state
//   disp_state/phase  : state and blink phase latched once per frame, used
//                       for colouring so nothing changes mid-frame
module alarm_blink_ctrl
    import alarm_pixel_compositor_pkg::*;
#(
    parameter int BLINK_FRAMES  = 30,
    parameter int SNOOZE_FRAMES = 600
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         frame_tick,
    input  logic         alarm_en,
    input  logic         alarm_ringing,
    input  logic         snooze,
    output alarm_state_e alarm_state,
    output alarm_state_e disp_state,
    output logic         disp_phase
);

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;

    localparam logic [31:0] RING_LIMIT   = 32'(BLINK_FRAMES - 1);
    localparam logic [31:0] SNZ_B_LIMIT  = 32'(2 * BLINK_FRAMES - 1);
    localparam logic [31:0] SNOOZE_LIMIT = 32'(SNOOZE_FRAMES - 1);

    alarm_state_e        state_q, state_d;
    alarm_state_e        disp_state_q, disp_state_d;
    logic                disp_phase_q, disp_phase_d;
    logic                phase_q, phase_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic [15:0]         snooze_cnt_q, snooze_cnt_d;

    logic [31:0]         blink_limit;
    logic                snooze_done;

    assign snooze_done = (32'(snooze_cnt_q) == SNOOZE_LIMIT);

    // Next-state logic; alarm_en=0 overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (!alarm_en) begin
            state_d = ALARM_OFF;
        end else begin
            case (state_q)
                ALARM_OFF: begin
                    state_d = ALARM_ARMED;
                end
                ALARM_ARMED: begin
                    if (alarm_ringing) begin
                        state_d = ALARM_RINGING;
                    end
                end
                ALARM_RINGING: begin
                    if (!alarm_ringing) begin
                        state_d = ALARM_ARMED;
                    end else if (snooze) begin
                        state_d = ALARM_SNOOZED;
                    end
                end
                ALARM_SNOOZED: begin
                    if (!alarm_ringing) begin
                        state_d = ALARM_ARMED;
                    end else if (frame_tick && snooze_done) begin
                        state_d = ALARM_RINGING;
                    end
                end
                default: begin
                    state_d = ALARM_OFF;
                end
            endcase
        end
    end

    // Blink/snooze counters. A state change restarts timing from a visible
    // phase and takes precedence over a coincident frame_tick.
    always_comb begin
        blink_cnt_d  = blink_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        phase_d      = phase_q;
        blink_limit  = (state_q == ALARM_SNOOZED) ? SNZ_B_LIMIT : RING_LIMIT;

        if (state_d != state_q) begin
            blink_cnt_d  = '0;
            snooze_cnt_d = '0;
            phase_d      = 1'b1;
        end else if (frame_tick) begin
            if ((state_q == ALARM_RINGING) || (state_q == ALARM_SNOOZED)) begin
                if (32'(blink_cnt_q) == blink_limit) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
            if ((state_q == ALARM_SNOOZED) && !snooze_done) begin
                snooze_cnt_d = snooze_cnt_q + 16'd1;
            end
        end
    end

    // Display copies only move on frame_tick so colours are stable per frame.
    always_comb begin
        disp_state_d = disp_state_q;
        disp_phase_d = disp_phase_q;
        if (frame_tick) begin
            disp_state_d = state_q;
            disp_phase_d = phase_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ALARM_OFF;
            blink_cnt_q  <= '0;
            snooze_cnt_q <= '0;
            phase_q      <= 1'b1;
            disp_state_q <= ALARM_OFF;
            disp_phase_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            blink_cnt_q  <= blink_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            phase_q      <= phase_d;
            disp_state_q <= disp_state_d;
            disp_phase_q <= disp_phase_d;
        end
    end

    assign alarm_state = state_q;
    assign disp_state  = disp_state_q;
    assign disp_phase  = disp_phase_q;

endmodule

// File: rtl/alarm_pixel_compositor.sv
// alarm_pixel_compositor: final colour stage of the alarm-clock VGA path.
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   bus (slave)  : renderer on-flags, sync-stage timing and alarm controls in;
//                  registered rgb, delayed hsync/vsync and alarm_state out.
// rgb, hsync_out and vsync_out are all registered once so they stay aligned.
module alarm_pixel_compositor
    import alarm_pixel_compositor_pkg::*;
#(
    parameter int     BLINK_FRAMES       = 30,
    parameter int     SNOOZE_FRAMES      = 600,
    parameter color_t COLOR_BG           = DEF_COLOR_BG,
    parameter color_t COLOR_TIME         = DEF_COLOR_TIME,
    parameter color_t COLOR_ALARM_DIGITS = DEF_COLOR_ALARM_DIGITS,
    parameter color_t COLOR_ALARM_TEXT   = DEF_COLOR_ALARM_TEXT,
    parameter color_t COLOR_DIM          = DEF_COLOR_DIM,
    parameter color_t COLOR_RING_BG      = DEF_COLOR_RING_BG
) (
    input  logic                     clk,
    input  logic                     reset_n,
    alarm_pixel_compositor_if.slave  bus
);

    alarm_state_e alarm_state;
    alarm_state_e disp_state;
    logic         disp_phase;

    color_t       rgb_q, rgb_d;
    logic         hsync_q, vsync_q;
    color_t       caption_color;
    color_t       bg_color;
    logic         caption_vis;

    alarm_blink_ctrl #(
        .BLINK_FRAMES  (BLINK_FRAMES),
        .SNOOZE_FRAMES (SNOOZE_FRAMES)
    ) u_blink_ctrl (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_tick    (bus.frame_tick),
        .alarm_en      (bus.alarm_en),
        .alarm_ringing (bus.alarm_ringing),
        .snooze        (bus.snooze),
        .alarm_state   (alarm_state),
        .disp_state    (disp_state),
        .disp_phase    (disp_phase)
    );

    // Colour priority: blanking, caption, alarm digits, time digits, background.
    always_comb begin
        caption_vis   = caption_visible(disp_state, disp_phase);
        caption_color = (disp_state == ALARM_OFF) ? COLOR_DIM : COLOR_ALARM_TEXT;
        bg_color      = ((disp_state == ALARM_RINGING) && disp_phase) ? COLOR_RING_BG : COLOR_BG;
        rgb_d         = '0;
        if (!bus.video_on) begin
            rgb_d = '0;
        end else if (bus.alarm_text_on && caption_vis) begin
            rgb_d = caption_color;
        end else if (bus.alarm_digits_on) begin
            rgb_d = COLOR_ALARM_DIGITS;
        end else if (bus.time_on) begin
            rgb_d = COLOR_TIME;
        end else begin
            rgb_d = bg_color;
        end
    end

    // Output registers; syncs idle high (inactive) during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= bus.hsync_in;
            vsync_q <= bus.vsync_in;
        end
    end

    assign bus.rgb         = rgb_q;
    assign bus.hsync_out   = hsync_q;
    assign bus.vsync_out   = vsync_q;
    assign bus.alarm_state = alarm_state;

endmodule

// File: tb/tb_alarm_pixel_compositor.sv
// Self-checking bench for alarm_pixel_compositor (BLINK_FRAMES=2,
// SNOOZE_FRAMES=4, frame_tick every 16 cycles). Inputs change on the falling
// edge; a reference model of the alarm/blink rules is stepped after every
// rising edge and compared with the outputs, and directed expectations
// posted by the stimulus are checked at the same point.
module tb_alarm_pixel_compositor;

    localparam int BF = 2;
    localparam int SF = 4;

    logic clk;
    logic reset_n;

    alarm_pixel_compositor_if bus ();

    alarm_pixel_compositor #(
        .BLINK_FRAMES  (BF),
        .SNOOZE_FRAMES (SF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;

    int    fcnt     = 0;

    int    lit_req  = 0;
    int    lit_seen = 0;
    string lit_tag  = "";
    int    lit_rgb  = -1;
    int    lit_state = -1;
    int    lit_sync = -1;

    // Model: states 0 OFF, 1 ARMED, 2 RINGING, 3 SNOOZED.
    int        m_state, m_blink, m_snz, m_dstate;
    bit        m_phase, m_dphase;
    bit [11:0] m_rgb;
    bit        m_hs, m_vs;

    function automatic bit [11:0] model_color(bit vid, bit txt, bit dig, bit tim, int dst, bit dph);
        bit vis;
        vis = (dst == 0) || (dst == 1) || dph;
        if (!vid) return 12'h000;
        if (txt && vis) return (dst == 0) ? 12'h444 : 12'hF00;
        if (dig) return 12'h0F0;
        if (tim) return 12'hFFF;
        if (dst == 2 && dph) return 12'h400;
        return 12'h000;
    endfunction

    function automatic int model_next(int st, bit en, bit ring, bit snz, bit tick, int scnt);
        if (!en) return 0;
        if (st == 0) return 1;
        if (st == 1) return ring ? 2 : 1;
        if (st == 2) begin
            if (!ring) return 1;
            return snz ? 3 : 2;
        end
        if (!ring) return 1;
        return (tick && scnt == SF - 1) ? 2 : 3;
    endfunction

    // Compare process: step the model per rising edge, then check.
    initial begin
        int  nxt;
        int  period;
        m_state = 0; m_blink = 0; m_snz = 0; m_dstate = 0;
        m_phase = 1; m_dphase = 1; m_rgb = 0; m_hs = 1; m_vs = 1;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                m_state = 0; m_blink = 0; m_snz = 0; m_dstate = 0;
                m_phase = 1; m_dphase = 1; m_rgb = 0; m_hs = 1; m_vs = 1;
            end else begin
                m_rgb = model_color(bus.video_on, bus.alarm_text_on, bus.alarm_digits_on,
                                    bus.time_on, m_dstate, m_dphase);
                m_hs  = bus.hsync_in;
                m_vs  = bus.vsync_in;
                nxt   = model_next(m_state, bus.alarm_en, bus.alarm_ringing, bus.snooze,
                                   bus.frame_tick, m_snz);
                if (bus.frame_tick) begin
                    m_dstate = m_state;
                    m_dphase = m_phase;
                end
                if (nxt != m_state) begin
                    m_blink = 0; m_snz = 0; m_phase = 1;
                end else if (bus.frame_tick && m_state >= 2) begin
                    period  = (m_state == 2) ? BF : 2 * BF;
                    m_blink = m_blink + 1;
                    if (m_blink == period) begin
                        m_blink = 0;
                        m_phase = !m_phase;
                    end
                    if (m_state == 3 && m_snz < SF - 1) m_snz = m_snz + 1;
                end
                m_state = nxt;
            end

            checks++;
            if (bus.rgb !== m_rgb) begin
                failures++;
                $display("[TB] FAIL model_rgb t=%0t got=%h expected=%h", $time, bus.rgb, m_rgb);
            end
            checks++;
            if (bus.hsync_out !== m_hs || bus.vsync_out !== m_vs) begin
                failures++;
                $display("[TB] FAIL model_sync t=%0t got=%b%b expected=%b%b", $time,
                         bus.hsync_out, bus.vsync_out, m_hs, m_vs);
            end
            checks++;
            if (bus.alarm_state !== 2'(m_state)) begin
                failures++;
                $display("[TB] FAIL model_state t=%0t got=%0d expected=%0d", $time, bus.alarm_state, m_state);
            end

            if (lit_req != lit_seen) begin
                if (lit_rgb >= 0) begin
                    checks++;
                    if (bus.rgb !== 12'(lit_rgb)) begin
                        failures++;
                        $display("[TB] FAIL %s rgb got=%h expected=%h", lit_tag, bus.rgb, 12'(lit_rgb));
                    end
                end
                if (lit_state >= 0) begin
                    checks++;
                    if (bus.alarm_state !== 2'(lit_state)) begin
                        failures++;
                        $display("[TB] FAIL %s state got=%0d expected=%0d", lit_tag, bus.alarm_state, lit_state);
                    end
                end
                if (lit_sync >= 0) begin
                    checks++;
                    if ({bus.hsync_out, bus.vsync_out} !== 2'(lit_sync)) begin
                        failures++;
                        $display("[TB] FAIL %s sync got=%b%b expected=%b", lit_tag,
                                 bus.hsync_out, bus.vsync_out, 2'(lit_sync));
                    end
                end
                lit_seen = lit_req;
            end
        end
    end

    // Drive n cycles; frame_tick every 16 cycles once out of reset.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            if (reset_n) begin
                bus.frame_tick = (fcnt == 15);
                fcnt           = (fcnt + 1) % 16;
                bus.hsync_in   = 1'($urandom_range(0, 1));
                bus.vsync_in   = 1'($urandom_range(0, 1));
            end else begin
                bus.frame_tick = 1'b0;
                bus.hsync_in   = 1'b0;
                bus.vsync_in   = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Advance until the next applied cycle carries frame_tick.
    task automatic runToTick();
        while (fcnt != 15) applyStimulus(1);
    endtask

    // Post a directed expectation for the outputs after the next rising edge
    // (-1 skips that field).
    task automatic checkOutput(input string tag, input int exp_rgb, input int exp_state, input int exp_sync);
        lit_tag   = tag;
        lit_rgb   = exp_rgb;
        lit_state = exp_state;
        lit_sync  = exp_sync;
        lit_req   = lit_req + 1;
    endtask

    task automatic setFlags(input bit vid, input bit txt, input bit dig, input bit tim);
        bus.video_on        = vid;
        bus.alarm_text_on   = txt;
        bus.alarm_digits_on = dig;
        bus.time_on         = tim;
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.frame_tick    = 1'b0;
        bus.hsync_in      = 1'b0;
        bus.vsync_in      = 1'b0;
        bus.alarm_en      = 1'b0;
        bus.alarm_ringing = 1'b0;
        bus.snooze        = 1'b0;
        setFlags(1, 0, 0, 0);

        $display("[TB] reset phase");
        checkOutput("reset", 12'h000, 0, 2'b11);
        applyStimulus(3);
        reset_n = 1'b1;
        applyStimulus(1);

        setFlags(1, 1, 0, 0);
        checkOutput("dim_caption", 12'h444, 0, -1);
        applyStimulus(1);
        setFlags(1, 0, 0, 1);
        checkOutput("time_digits", 12'hFFF, 0, -1);
        applyStimulus(1);

        $display("[TB] armed");
        bus.alarm_en = 1'b1;
        setFlags(1, 1, 0, 0);
        checkOutput("armed_enter", 12'h444, 1, -1);
        applyStimulus(1);
        runToTick();
        applyStimulus(1);
        checkOutput("armed_caption", 12'hF00, 1, -1);
        applyStimulus(1);
        setFlags(1, 0, 1, 1);
        checkOutput("digits_priority", 12'h0F0, 1, -1);
        applyStimulus(1);
        setFlags(1, 1, 1, 1);
        checkOutput("caption_priority", 12'hF00, 1, -1);
        applyStimulus(1);

        $display("[TB] ringing");
        setFlags(1, 1, 0, 0);
        bus.alarm_ringing = 1'b1;
        checkOutput("ring_enter", 12'hF00, 2, -1);
        applyStimulus(1);
        runToTick();
        applyStimulus(1);
        setFlags(1, 0, 0, 0);
        checkOutput("ring_bg_on", 12'h400, 2, -1);
        applyStimulus(1);
        runToTick();
        applyStimulus(1);
        runToTick();
        applyStimulus(1);
        setFlags(1, 1, 0, 0);
        checkOutput("ring_caption_off", 12'h000, 2, -1);
        applyStimulus(1);

        $display("[TB] snooze");
        bus.snooze = 1'b1;
        checkOutput("snooze_enter", 12'h000, 3, -1);
        applyStimulus(1);
        bus.snooze = 1'b0;
        runToTick();
        applyStimulus(1);
        checkOutput("snooze_caption", 12'hF00, 3, -1);
        applyStimulus(1);
        runToTick();
        applyStimulus(1);
        runToTick();
        applyStimulus(1);
        runToTick();
        checkOutput("rering", 12'hF00, 2, -1);
        applyStimulus(1);

        $display("[TB] edge cases");
        bus.snooze        = 1'b1;
        bus.alarm_ringing = 1'b0;
        checkOutput("snooze_vs_fall", 12'hF00, 1, -1);
        applyStimulus(1);
        bus.snooze        = 1'b0;
        bus.alarm_ringing = 1'b1;
        applyStimulus(1);
        bus.alarm_en = 1'b0;
        checkOutput("en_drop", -1, 0, -1);
        applyStimulus(1);
        runToTick();
        applyStimulus(1);
        checkOutput("dim_next_frame", 12'h444, 0, -1);
        applyStimulus(1);
        setFlags(0, 1, 1, 1);
        checkOutput("blanking", 12'h000, 0, -1);
        applyStimulus(1);

        $display("[TB] mixed traffic");
        bus.alarm_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            setFlags(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 60) == 0) bus.alarm_en = ~bus.alarm_en;
            if ($urandom_range(0, 40) == 0) bus.alarm_ringing = ~bus.alarm_ringing;
            bus.snooze = 1'($urandom_range(0, 25) == 0);
            applyStimulus(1);
        end
        bus.snooze = 1'b0;
        applyStimulus(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_pixel_compositor.md
Name: alarm_pixel_compositor

Overview:
- Downstream of the text/digit bitmap renderers in the alarm-clock VGA path. Consumes their per-pixel "on" flags plus the sync-stage timing signals and produces the registered 12-bit RGB (4:4:4) and aligned sync outputs for the VGA pins.
- Owns the alarm display state machine and the frame-counted blink/snooze timing, so the "ALARM" caption dims, glows or flashes according to alarm status.

Parameters:
- BLINK_FRAMES, 30, frames per blink half-period in RINGING; SNOOZED uses 2*BLINK_FRAMES.
- SNOOZE_FRAMES, 600, frames spent in SNOOZED before re-ringing; maximum 65535.
- COLOR_BG, 12'h000, background.
- COLOR_TIME, 12'hFFF, current-time digits.
- COLOR_ALARM_DIGITS, 12'h0F0, alarm-time digits.
- COLOR_ALARM_TEXT, 12'hF00, "ALARM" caption when active.
- COLOR_DIM, 12'h444, caption when alarm disabled.
- COLOR_RING_BG, 12'h400, background during the RINGING visible phase.

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- video_on  in  1  active display area.
- hsync_in  in  1  horizontal sync from the sync stage (active-low).
- vsync_in  in  1  vertical sync from the sync stage (active-low).
- frame_tick  in  1  one-cycle pulse per frame, start of vblank.
- time_on  in  1  current-time digit pixel.
- alarm_digits_on  in  1  alarm-time digit pixel.
- alarm_text_on  in  1  "ALARM" caption pixel.
- alarm_en  in  1  alarm enabled (level).
- alarm_ringing  in  1  alarm time matched (level).
- snooze  in  1  one-cycle snooze request.
- rgb  out  12  registered pixel colour.
- hsync_out  out  1  hsync_in delayed 1 cycle.
- vsync_out  out  1  vsync_in delayed 1 cycle.
- alarm_state  out  2  FSM state: 0 OFF, 1 ARMED, 2 RINGING, 3 SNOOZED.

Behaviour:
- Reset (async, reset_n=0) sets:
  - rgb=0, hsync_out=1, vsync_out=1.
  - alarm_state=OFF; blink_cnt=0, snooze_cnt=0; phase=1 (visible); disp_state=OFF.
- FSM transitions, evaluated every clk, in priority order:
  - alarm_en=0 forces OFF from any state.
  - OFF -> ARMED when alarm_en=1.
  - ARMED -> RINGING when alarm_ringing=1.
  - RINGING -> ARMED when alarm_ringing=0.
  - Otherwise RINGING -> SNOOZED on snooze=1.
  - SNOOZED -> ARMED when alarm_ringing=0.
  - SNOOZED -> RINGING on the frame_tick where snooze_cnt==SNOOZE_FRAMES-1 and alarm_ringing=1.
  - snooze is ignored outside RINGING.
- Counters:
  - Any state change clears blink_cnt and snooze_cnt and sets phase=1. A state change wins over a frame_tick in the same cycle.
  - blink_cnt advances on frame_tick in RINGING/SNOOZED. At its limit (BLINK_FRAMES-1 in RINGING, 2*BLINK_FRAMES-1 in SNOOZED) it wraps to 0 and phase toggles.
  - snooze_cnt advances on frame_tick in SNOOZED only and saturates at SNOOZE_FRAMES-1.
- Anti-tearing: disp_state and disp_phase latch alarm_state and phase only on frame_tick, so colours never change mid-frame. Exception: reset, which sets both directly.
- Colour select (combinational, then registered):
  - video_on=0 -> 0.
  - else alarm_text_on and caption visible -> caption colour.
  - else alarm_digits_on -> COLOR_ALARM_DIGITS.
  - else time_on -> COLOR_TIME.
  - else background.
- Caption colour and visibility per disp_state:
  - OFF: COLOR_DIM, visible.
  - ARMED: COLOR_ALARM_TEXT, visible.
  - RINGING/SNOOZED: COLOR_ALARM_TEXT, visible only when disp_phase=1.
- Background: COLOR_RING_BG when disp_state=RINGING and disp_phase=1; otherwise COLOR_BG.
- Latency: rgb, hsync_out and vsync_out are all exactly 1 cycle after their inputs, so they stay mutually aligned.
- Width rules:
  - blink_cnt is $clog2(2*BLINK_FRAMES) bits.
  - snooze_cnt is 16 bits.
  - Limit comparisons are at full width, with no truncation.

Decomposition:
- Shared display package:
  - alarm-state enum (OFF/ARMED/RINGING/SNOOZED, 2-bit encoding as above).
  - 12-bit colour typedef.
  - default colour constants.
- One natural sub-module: alarm_blink_ctrl, holding the FSM, blink/snooze counters and frame-latched disp_state/disp_phase.
- The top level holds the colour priority mux and the output/sync registers.

Test Plan (BLINK_FRAMES=2, SNOOZE_FRAMES=4, frame_tick every 16 cycles):
- Reset, then video_on=1 with all on-flags 0 -> rgb=12'h000, hsync_out=vsync_out=1 during reset. After reset, rgb follows inputs with 1-cycle latency.
- alarm_en=0, alarm_text_on=1 -> rgb=12'h444 one cycle later.
- alarm_en=1, then alarm_text_on=1 -> alarm_state=1; after the next frame_tick rgb=12'hF00. alarm_digits_on and time_on set together with no caption pixel -> rgb=12'h0F0 (priority).
- alarm_ringing=1 -> state 2. Caption pixel alternates F00/background every 2 frames. Non-caption background alternates 12'h400/12'h000, changing only one cycle after a frame_tick.
- snooze pulse in RINGING -> state 3, caption toggles every 4 frames. After the 4th frame_tick with ringing held -> state 2.
- Same-cycle snooze and alarm_ringing falling -> ARMED. alarm_en dropped mid-RINGING -> OFF immediately and rgb=12'h444 from the next frame. video_on=0 -> rgb=0 regardless of flags.
